seg7_mod_counter: RTL and testbench
===================================

# seg7_mod_counter

Parametrised modulo up/down counter with a built-in prescaler, terminal-count pulse and a time-multiplexed hexadecimal 7-segment driver. It succeeds the fixed 4-bit single-digit counter/display: width, modulus, count direction, tick rate and digit count are all configurable. It sits between the top-level `ui_in` controls and the `uo_out`/`uio_out` display pins of a Tiny Tapeout user project.

## Interface
- WIDTH, 8, counter width in bits; multiple of 4, range 4..16; DIGITS = WIDTH/4
- PRESCALE, 1, clock cycles per count tick; ≥1; 1 = tick every enabled cycle
- SCAN_DIV, 4, clock cycles each digit stays selected; ≥1

- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- en  in  1  count enable; gates the prescaler
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load strobe; priority over counting
- load_val  in  WIDTH  value loaded on `load`
- limit  in  WIDTH  modulus minus one; count range is 0..limit
- count  out  WIDTH  current count value
- tc  out  1  registered one-cycle terminal-count pulse
- seg  out  7  segments, active high; seg[0]=a … seg[6]=g
- dig_sel  out  DIGITS  one-hot digit select, active high; bit d shows nibble d of count

## Operation
- Prescaler `pre`, range 0..PRESCALE-1: advances only while en=1; `tick` = en && pre==PRESCALE-1; pre wraps to 0 on tick; holds while en=0; cleared on load.
- Count update, priority order:
  - load=1: count <= (load_val > limit) ? limit : load_val; tc <= 0; no tick this cycle.
  - tick && up: count <= (count >= limit) ? 0 : count+1; wrap when count >= limit.
  - tick && !up: count <= (count == 0 || count > limit) ? limit : count-1; wrap when count == 0.
  - otherwise: hold.
- tc is asserted for exactly the one cycle after a wrapping tick; otherwise 0.
- limit=0: count stays 0 and every tick wraps, so tc pulses once per tick.
- limit may change at any time. A count above the new limit resolves on the next tick: 0 when counting up, limit when counting down. No tick means the value holds.
- Arithmetic is unsigned WIDTH-bit; no intermediate value exceeds WIDTH bits.
- Scan:
  - Divider `sdiv`, 0..SCAN_DIV-1, runs free and is independent of en.
  - Digit index `d`, 0..DIGITS-1, advances when sdiv wraps and wraps to 0 after DIGITS-1.
  - dig_sel <= one-hot(d).
  - seg <= hex7(count[4d+3:4d]).
- hex7 patterns (g..a), 0–F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- DIGITS=1: dig_sel is constant 1 and seg tracks count[3:0].

## Timing
- Reset (rst_n=0, asynchronous): count=0, pre=0, tc=0, sdiv=0, d=0, dig_sel=1, seg=0x3F. Outputs take these values immediately, without waiting for a clock edge.
- Release is synchronous: the first edge with rst_n=1 is the first active edge.
- Reset asserted mid-count or mid-scan aborts immediately. No tc is generated for the lost state.
- count changes on the edge where tick or load is sampled, i.e. latency 1 from inputs.
- tc: high in the cycle after the wrapping edge, for exactly one cycle.
- seg/dig_sel are registered from the current count and d, so seg lags count by 1 cycle.
- seg and dig_sel always change on the same edge. There is never a cycle where seg shows nibble d while another digit is selected.
- Digit dwell: exactly SCAN_DIV cycles per digit; full frame = DIGITS·SCAN_DIV cycles.
- load and tick in the same cycle: load wins and the prescaler restarts at 0. The next tick comes PRESCALE enabled cycles later.

## Test plan
- Reset/idle:
  - Stimulus: WIDTH=8, hold rst_n=0 and check outputs; release with en=0 for 20 cycles.
  - Required: during reset count=0, tc=0, dig_sel=01, seg=0x3F. After release count stays 0 and dig_sel alternates 01/10 every 4 cycles.
- Up wrap:
  - Stimulus: PRESCALE=1, limit=9, up=1, en=1 from 0.
  - Required: count runs 0..9 then 0. tc high only in the cycle after the 9→0 edge, every 10 cycles.
- Down wrap with prescale:
  - Stimulus: PRESCALE=3, limit=5, up=0, load 2.
  - Required: count 2→1→0→5 with each step exactly 3 enabled cycles apart. tc pulses once after 0→5. Dropping en for 7 cycles stretches the step by exactly 7 cycles.
- Load clamp and priority:
  - Stimulus: limit=0x20; load_val=0x35 with load=1 on a tick cycle.
  - Required: count=0x20 next cycle, tc=0. Next up tick gives count=0x00 with a tc pulse.
- Limit lowered / limit=0:
  - Stimulus: count=0x40, then limit set to 0x10; next up tick; then set limit=0.
  - Required: count=0x00 with tc on the tick after the limit change. With limit=0, count stays 0 and tc pulses every tick.
- Display decode:
  - Stimulus: WIDTH=8, load 0xA7, en=0.
  - Required: digit 0 shows seg=0x07 with dig_sel=01; digit 1 shows seg=0x77 with dig_sel=10. Pair alternation is aligned, and reset mid-frame returns to dig_sel=01, seg=0x3F asynchronously.

Source files
------------

// File: rtl/seg7_mod_counter.sv
// Modulo up/down counter with prescaler, terminal-count pulse and a
// time-multiplexed hexadecimal 7-segment display driver.
module seg7_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned SCAN_DIV = 4,
    localparam int unsigned DIGITS  = WIDTH / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_sel
);

    localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned SDIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              tc_q, tc_d;
    logic [SDIV_W-1:0] sdiv_q, sdiv_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic              tick;
    logic [3:0]        nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick = en && (pre_q == PRE_LAST);

    // Load outranks a tick and restarts the prescaler; counts above limit
    // resolve to 0 (up) or limit (down) on the next tick.
    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            pre_d   = '0;
            count_d = (load_val > limit) ? limit : load_val;
        end else begin
            if (en) begin
                pre_d = tick ? '0 : pre_q + PRE_W'(1);
            end
            if (tick) begin
                if (up) begin
                    if (count_q >= limit) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = limit;
                        tc_d    = 1'b1;
                    end else if (count_q > limit) begin
                        count_d = limit;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        nibble = count_q[3:0];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit_q == DIG_W'(i)) begin
                nibble = count_q[4*i +: 4];
            end
        end
    end

    // seg and dig_sel are both built from the same digit index, so they
    // always switch together one cycle after the index moves.
    always_comb begin
        sdiv_d    = (sdiv_q == SDIV_LAST) ? '0 : sdiv_q + SDIV_W'(1);
        digit_d   = digit_q;
        if (sdiv_q == SDIV_LAST) begin
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
        end
        dig_sel_d = DIGITS'(1) << digit_q;
        seg_d     = hex7(nibble);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            count_q   <= '0;
            tc_q      <= 1'b0;
            sdiv_q    <= '0;
            digit_q   <= '0;
            seg_q     <= 7'h3F;
            dig_sel_q <= DIGITS'(1);
        end else begin
            pre_q     <= pre_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            sdiv_q    <= sdiv_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg7_mod_counter.sv
// Bench for seg7_mod_counter: two instances (PRESCALE 1 and 3) share stimulus
// and are compared each cycle against a cycle-count based reference model.
module tb_seg7_mod_counter;

    localparam int SCAN_DIV = 4;
    localparam int DIGITS   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] limit = 8'hFF;

    logic [7:0] count1, count3;
    logic       tc1, tc3;
    logic [6:0] seg1, seg3;
    logic [1:0] dig1, dig3;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int ps [2] = '{1, 3};
    int m_count [2];
    int m_pre [2];
    int m_tc [2];
    int m_seg [2];
    int m_dig;
    int k;

    seg7_mod_counter #(.WIDTH(8), .PRESCALE(1), .SCAN_DIV(SCAN_DIV)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .limit(limit), .count(count1), .tc(tc1), .seg(seg1), .dig_sel(dig1)
    );

    seg7_mod_counter #(.WIDTH(8), .PRESCALE(3), .SCAN_DIV(SCAN_DIV)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .limit(limit), .count(count3), .tc(tc3), .seg(seg3), .dig_sel(dig3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check("count_p1", 32'(count1), 32'(m_count[0]));
        check("tc_p1", 32'(tc1), 32'(m_tc[0]));
        check("seg_p1", 32'(seg1), 32'(m_seg[0]));
        check("dig_sel_p1", 32'(dig1), 32'(m_dig));
        check("count_p3", 32'(count3), 32'(m_count[1]));
        check("tc_p3", 32'(tc3), 32'(m_tc[1]));
        check("seg_p3", 32'(seg3), 32'(m_seg[1]));
        check("dig_sel_p3", 32'(dig3), 32'(m_dig));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = 0;
            m_pre[i]   = 0;
            m_tc[i]    = 0;
            m_seg[i]   = 'h3F;
        end
        m_dig = 1;
        k     = 0;
    endtask

    // Display shows the digit selected by elapsed cycles one edge ago.
    task automatic model_edge();
        int dprev;
        int lim;
        int lv;
        bit tick;
        dprev = (k / SCAN_DIV) % DIGITS;
        lim   = int'(limit);
        lv    = int'(load_val);
        for (int i = 0; i < 2; i++) begin
            m_seg[i] = int'(hex_tab[(m_count[i] >> (4 * dprev)) & 15]);
        end
        m_dig = 1 << dprev;
        k++;
        for (int i = 0; i < 2; i++) begin
            m_tc[i] = 0;
            if (load) begin
                m_count[i] = (lv > lim) ? lim : lv;
                m_pre[i]   = 0;
            end else begin
                tick = 1'b0;
                if (en) begin
                    m_pre[i]++;
                    if (m_pre[i] == ps[i]) begin
                        m_pre[i] = 0;
                        tick     = 1'b1;
                    end
                end
                if (tick && up) begin
                    if (m_count[i] >= lim) begin
                        m_count[i] = 0;
                        m_tc[i]    = 1;
                    end else begin
                        m_count[i]++;
                    end
                end else if (tick) begin
                    if (m_count[i] == 0) begin
                        m_count[i] = lim;
                        m_tc[i]    = 1;
                    end else if (m_count[i] > lim) begin
                        m_count[i] = lim;
                    end else begin
                        m_count[i]--;
                    end
                end
            end
        end
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_edge();
            #1;
            check_all();
        end
    endtask

    // Reset mid-cycle: outputs must drop to reset values before any edge.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all();
        step(2);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after release: counts hold, digits scan.
        en = 1'b0;
        step(20);

        // Up wrap with limit 9.
        limit = 8'd9;
        up    = 1'b1;
        en    = 1'b1;
        step(25);

        // Down wrap from a loaded 2 with limit 5, then an en gap.
        limit    = 8'd5;
        up       = 1'b0;
        load_val = 8'd2;
        load     = 1'b1;
        step(1);
        load = 1'b0;
        step(12);
        en = 1'b0;
        step(7);
        en = 1'b1;
        step(12);

        // Clamped load on a tick cycle, then up wrap from the limit.
        limit    = 8'h20;
        load_val = 8'h35;
        load     = 1'b1;
        step(1);
        load = 1'b0;
        up   = 1'b1;
        step(6);

        // Limit lowered below the count, then limit 0.
        limit    = 8'hFF;
        load_val = 8'h40;
        load     = 1'b1;
        step(1);
        load  = 1'b0;
        limit = 8'h10;
        step(4);
        limit = 8'h00;
        step(8);
        up = 1'b0;
        step(6);

        // Display decode of 0xA7, then reset in the middle of a frame.
        limit    = 8'hFF;
        load_val = 8'hA7;
        load     = 1'b1;
        en       = 1'b0;
        step(1);
        load = 1'b0;
        step(13);
        async_reset();
        step(6);

        // Randomised traffic with one extra asynchronous reset.
        for (int r = 0; r < 400; r++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                limit = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            end
            if (r == 200) async_reset();
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
